// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite master command port among
// NUM_REQ requesters. Only one transaction is in flight at a time. Each
// completion (response and read data) is routed back to the requester that
// issued it, as a one-cycle pulse.
module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_REQ-1:0]     rq_valid,
  input  logic [NUM_REQ-1:0]     rq_write,
  input  logic [32*NUM_REQ-1:0]  rq_addr,
  input  logic [32*NUM_REQ-1:0]  rq_wdata,
  input  logic [4*NUM_REQ-1:0]   rq_strb,
  output logic [NUM_REQ-1:0]     rq_done,
  output logic [31:0]            rq_rdata,
  output logic [1:0]             rq_resp,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   wr_req,
  output logic                   rd_req,
  output logic [31:0]            wr_addr,
  output logic [31:0]            wr_data,
  output logic [3:0]             wr_strb,
  output logic [31:0]            rd_addr,
  input  logic                   wr_done,
  input  logic                   rd_done,
  input  logic [1:0]             wr_resp,
  input  logic [1:0]             rd_resp,
  input  logic [31:0]            rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] DONE_LSB = NUM_REQ'(1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              lat_write;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_strb;
  logic              done_hit;

  // Only the completion matching the issued direction ends the wait.
  assign done_hit = lat_write ? wr_done : rd_done;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping,
  // plus a mux of that requester's command fields.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    sel_write  = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_strb   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && rq_valid[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_write = rq_write[i];
        sel_addr  = rq_addr[32*i +: 32];
        sel_wdata = rq_wdata[32*i +: 32];
        sel_strb  = rq_strb[4*i +: 4];
      end
    end
  end

  // Next-state logic; ISSUE and RESP each last exactly one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Registered outputs: command latch at grant, completion latch in WAIT,
  // return pulse in RESP. busy tracks the state being entered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      lat_write <= 1'b0;
      wr_req    <= 1'b0;
      rd_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= 4'h0;
      rd_addr   <= '0;
      rq_done   <= '0;
      rq_rdata  <= '0;
      rq_resp   <= '0;
      busy      <= 1'b0;
    end else begin
      wr_req  <= 1'b0;
      rd_req  <= 1'b0;
      rq_done <= '0;
      busy    <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            lat_write <= sel_write;
            if (sel_write) begin
              wr_addr <= sel_addr;
              wr_data <= sel_wdata;
              wr_strb <= sel_strb;
              wr_req  <= 1'b1;
            end else begin
              rd_addr <= sel_addr;
              rd_req  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (done_hit) begin
            rq_done  <= DONE_LSB << grant_idx;
            rq_resp  <= lat_write ? wr_resp : rd_resp;
            rq_rdata <= lat_write ? 32'h0 : rd_data;
          end
        end
        RESP: begin
          rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
          rq_rdata <= '0;
          rq_resp  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter: directed scenarios followed by randomized
// traffic, checked against a round-robin reference model.
module tb_axi_lite_cmd_arbiter;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [N-1:0]      rq_valid = '0;
  logic [N-1:0]      rq_write = '0;
  logic [32*N-1:0]   rq_addr = '0;
  logic [32*N-1:0]   rq_wdata = '0;
  logic [4*N-1:0]    rq_strb = '0;
  logic [N-1:0]      rq_done;
  logic [31:0]       rq_rdata;
  logic [1:0]        rq_resp;
  logic              busy;
  logic [IW-1:0]     grant_idx;
  logic              wr_req, rd_req;
  logic [31:0]       wr_addr, wr_data, rd_addr;
  logic [3:0]        wr_strb;
  logic              wr_done = 1'b0, rd_done = 1'b0;
  logic [1:0]        wr_resp = '0, rd_resp = '0;
  logic [31:0]       rd_data = '0;

  axi_lite_cmd_arbiter #(.NUM_REQ(N)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr),
    .rq_wdata(rq_wdata), .rq_strb(rq_strb),
    .rq_done(rq_done), .rq_rdata(rq_rdata), .rq_resp(rq_resp),
    .busy(busy), .grant_idx(grant_idx),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .rd_addr(rd_addr),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_resp(wr_resp), .rd_resp(rd_resp), .rd_data(rd_data)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model state: round-robin pointer and each requester's request.
  int          mdl_ptr = 0;
  logic        m_write [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_wdata [N];
  logic [3:0]  m_strb  [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    m_write[i] = w;  m_addr[i] = a;  m_wdata[i] = d;  m_strb[i] = s;
    rq_write[i] = w;
    rq_addr[32*i +: 32]  = a;
    rq_wdata[32*i +: 32] = d;
    rq_strb[4*i +: 4]    = s;
    rq_valid[i] = 1'b1;
  endtask

  task automatic clr_req(input int i);
    rq_valid[i] = 1'b0;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
  endtask

  // Model: first valid requester searching upward from the pointer.
  function automatic int mdl_pick();
    for (int k = 0; k < N; k++) begin
      if (rq_valid[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  // Acts as the AXI-Lite master for one transaction. Called at a negedge with
  // requests already driven; returns at the negedge where rq_done is high.
  task automatic serve(input int lat, input bit spur, input logic [31:0] rdat,
                       input logic [1:0] rsp, output int gidx, output int wcyc);
    int  e;
    bit  seen;
    logic w;
    e = mdl_pick();
    seen = 0;
    wcyc = 0;
    gidx = e;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge aclk);
      wcyc++;
      if (wr_req || rd_req) seen = 1;
    end
    chk("req_seen", 64'(seen), 64'd1);
    if (!seen || e < 0) return;
    w = m_write[e];
    chk("grant_idx", 64'(grant_idx), 64'(e));
    chk("wr_req", 64'(wr_req), 64'(w));
    chk("rd_req", 64'(rd_req), 64'(!w));
    chk("busy_issue", 64'(busy), 64'd1);
    if (w) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr[e]));
      chk("wr_data", 64'(wr_data), 64'(m_wdata[e]));
      chk("wr_strb", 64'(wr_strb), 64'(m_strb[e]));
    end else begin
      chk("rd_addr", 64'(rd_addr), 64'(m_addr[e]));
    end
    // Opposite done during ISSUE must be ignored.
    if (spur) begin
      if (w) begin rd_done = 1'b1; rd_resp = 2'($urandom); rd_data = $urandom; end
      else   begin wr_done = 1'b1; wr_resp = 2'($urandom); end
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge aclk);
      wr_done = 1'b0;
      rd_done = 1'b0;
      chk("no_req_wait", 64'({wr_req, rd_req}), 64'd0);
      chk("no_done_wait", 64'(rq_done), 64'd0);
      chk("hold_addr", 64'(w ? wr_addr : rd_addr), 64'(m_addr[e]));
      if (c == lat) begin
        if (w) begin wr_done = 1'b1; wr_resp = rsp; end
        else   begin rd_done = 1'b1; rd_resp = rsp; rd_data = rdat; end
      end else if (spur) begin
        if (w) begin rd_done = 1'b1; rd_resp = 2'($urandom); rd_data = $urandom; end
        else   begin wr_done = 1'b1; wr_resp = 2'($urandom); end
      end
    end
    @(negedge aclk);
    wr_done = 1'b0;
    rd_done = 1'b0;
    rd_data = $urandom;
    chk("rq_done", 64'(rq_done), 64'(1 << e));
    chk("rq_rdata", 64'(rq_rdata), 64'(w ? 32'h0 : rdat));
    chk("rq_resp", 64'(rq_resp), 64'(rsp));
    chk("busy_resp", 64'(busy), 64'd1);
    mdl_ptr = (e + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int g, wc;
    bit seen;
    int prev;

    // Reset values
    repeat (2) @(negedge aclk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'({wr_req, rd_req}), 64'd0);
    chk("rst_done", 64'(rq_done), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_rdata", 64'(rq_rdata), 64'd0);
    chk("rst_resp", 64'(rq_resp), 64'd0);
    chk("rst_wcmd", {wr_addr, wr_data}, 64'd0);
    chk("rst_rcmd", 64'({wr_strb, rd_addr}), 64'd0);
    aresetn = 1'b1;

    // Spurious completions while idle
    @(negedge aclk);
    wr_done = 1'b1; wr_resp = 2'b11;
    @(negedge aclk);
    wr_done = 1'b0; rd_done = 1'b1; rd_data = 32'hDEAD_BEEF;
    @(negedge aclk);
    rd_done = 1'b0;
    chk("idle_spur_busy", 64'(busy), 64'd0);
    chk("idle_spur_done", 64'(rq_done), 64'd0);
    @(negedge aclk);
    chk("idle_spur_busy2", 64'(busy), 64'd0);

    // Single write from req0
    set_req(0, 1'b1, 32'h0000_0000, 32'hABCD_1234, 4'hF);
    serve(2, 0, 32'h0, 2'b00, g, wc);
    clr_req(0);

    // Single read from req1
    @(negedge aclk);
    set_req(1, 1'b0, 32'h0000_000C, 32'h0, 4'h0);
    serve(2, 0, 32'h3333_3333, 2'b00, g, wc);
    clr_req(1);

    // Response routing: req0 write with SLVERR, then req1 read OKAY
    @(negedge aclk);
    set_req(0, 1'b1, 32'h0000_0010, 32'h5555_AAAA, 4'h3);
    serve(1, 0, 32'h0, 2'b10, g, wc);
    clr_req(0);
    set_req(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    serve(1, 0, 32'h1234_5678, 2'b00, g, wc);
    clr_req(1);

    // Opposite-direction done pulses during a write's ISSUE/WAIT
    set_req(0, 1'b1, 32'h0000_0030, 32'h0F0F_0F0F, 4'hA);
    serve(3, 1, 32'h0, 2'b01, g, wc);
    clr_req(0);

    // Reset in WAIT of a req0 read; pointer is at 1 beforehand
    @(negedge aclk);
    set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge aclk);
      if (rd_req) seen = 1;
    end
    chk("rst_mid_rdreq", 64'(seen), 64'd1);
    @(negedge aclk);
    chk("rst_mid_busy_pre", 64'(busy), 64'd1);
    #2 aresetn = 1'b0;
    clr_req(0);
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_req", 64'({wr_req, rd_req}), 64'd0);
    chk("rst_mid_rdaddr", 64'(rd_addr), 64'd0);
    mdl_ptr = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    rd_done = 1'b1; rd_resp = 2'b11; rd_data = 32'hBAD0_BAD0;
    @(negedge aclk);
    rd_done = 1'b0;
    chk("late_done", 64'(rq_done), 64'd0);
    chk("late_busy", 64'(busy), 64'd0);
    @(negedge aclk);
    chk("late_busy2", 64'(busy), 64'd0);

    // Contention: req0 and req1 both held valid; expect 0,1,0,1
    rand_req(0);
    rand_req(1);
    for (int k = 0; k < 4; k++) begin
      serve(1 + (k % 2), 0, $urandom, 2'($urandom), g, wc);
      chk("rr_order", 64'(g), 64'(k % 2));
      if (k == 3) clr_req(0);
      else if (g >= 0) rand_req(g);
    end

    // req1 alone, two back-to-back writes
    set_req(1, 1'b1, 32'h0000_0100, 32'h1111_2222, 4'hC);
    serve(1, 0, 32'h0, 2'b00, g, wc);
    chk("b2b_first", 64'(g), 64'd1);
    set_req(1, 1'b1, 32'h0000_0104, 32'h3333_4444, 4'h6);
    serve(1, 0, 32'h0, 2'b00, g, wc);
    chk("b2b_second", 64'(g), 64'd1);
    chk("b2b_gap", 64'(wc), 64'd2);
    clr_req(1);

    // Randomized traffic against the model
    prev = -1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_valid[i] && ($urandom_range(2) == 0)) rand_req(i);
      end
      if (rq_valid == '0) rand_req(int'($urandom_range(N - 1)));
      serve(int'($urandom_range(4, 1)), bit'($urandom), $urandom, 2'($urandom), g, wc);
      if (g < 0) break;
      if ($urandom_range(1) == 0) rand_req(g);
      else clr_req(g);
      prev = g;
    end
    rq_valid = '0;
    repeat (3) @(negedge aclk);
    chk("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_arbiter.md
# axi_lite_cmd_arbiter

Round-robin arbiter that shares one AXI-Lite master command port (wr_req/rd_req pulse interface with done/resp return) among NUM_REQ independent requesters. It sits between software-side or DMA-side initiators and the AXI-Lite master. It serialises their reads and writes, holds one transaction in flight at a time, and routes each completion (data and response) back to the requester that issued it.

## Interface
- NUM_REQ, 2: number of requesters; valid range 2..8.
- IDX_W, $clog2(NUM_REQ): width of the grant index.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- rq_valid  in  NUM_REQ  per-requester request valid, level.
- rq_write  in  NUM_REQ  1 = write, 0 = read.
- rq_addr  in  32*NUM_REQ  byte address; requester i uses bits [32i+31:32i].
- rq_wdata  in  32*NUM_REQ  write data, same packing.
- rq_strb  in  4*NUM_REQ  write byte strobes, packed as [4i+3:4i].
- rq_done  out  NUM_REQ  one-hot completion pulse, 1 cycle.
- rq_rdata  out  32  read data; valid only while some rq_done bit is high.
- rq_resp  out  2  AXI response for the completed transaction.
- busy  out  1  high in every state other than IDLE.
- grant_idx  out  IDX_W  index of the current/last granted requester.
- wr_req, rd_req  out  1  one-cycle command pulses to the AXI-Lite master.
- wr_addr, wr_data  out  32 each  write command fields.
- wr_strb  out  4  write strobes.
- rd_addr  out  32  read address.
- wr_done, rd_done  in  1  completion from the master.
- wr_resp, rd_resp  in  2  response codes from the master.
- rd_data  in  32  read data from the master.

## Operation
- FSM with states IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any rq_valid bit is set: grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's write/addr/wdata/strb and set grant_idx.
  - Move to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Drive wr_req=1 for a write, otherwise rd_req=1.
  - Command fields come from the latched copy, never from rq_* directly.
  - Move to WAIT.
- **WAIT**
  - Hold all command fields stable.
  - Accept only the done matching the latched direction: wr_done for writes, rd_done for reads.
  - The opposite done is ignored.
  - On a match: latch the resp, and latch rd_data for reads; move to RESP.
  - No timeout; WAIT holds indefinitely.
- **RESP** (exactly 1 cycle)
  - rq_done[grant_idx]=1.
  - rq_rdata = latched read data, or 0 for writes.
  - rq_resp = latched resp.
  - rr_ptr becomes grant_idx+1 mod NUM_REQ.
  - Move to IDLE.
- **Requester rules**
  - Hold rq_valid and all fields stable from assertion until its rq_done.
  - rq_valid still high in the cycle after rq_done counts as a new request.
- wr_done/rd_done seen in IDLE, ISSUE or RESP: ignored, no state change.
- A requester dropping rq_valid before it is granted: legal, no side effects. Dropping it after grant: the transaction still completes and rq_done still pulses.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_idx 0.
  - wr_req, rd_req, rq_done, busy all 0.
  - rq_rdata, rq_resp, and all command address/data fields 0; wr_strb 4'h0.
- Latency:
  - rq_valid sampled high at edge T0 → ISSUE during T0..T1, so the req pulse is visible at edge T1.
  - Master done sampled high at edge Tn (in WAIT) → rq_done high during Tn..Tn+1.
  - Next arbitration decision at edge Tn+2.
- Minimum request-to-done: 3 cycles plus master latency.
- A done that coincides with the ISSUE cycle is ignored. The master must return done at least 1 cycle after req.
- Simultaneous requests: strictly round-robin. A requester never waits more than NUM_REQ-1 other transactions.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately (asynchronous).
  - The in-flight transaction is abandoned with no rq_done.
  - A late done after reset release lands in IDLE and is ignored.
- busy is registered and follows state exactly.

## Test plan
- **Single write:** req0 writes 0xABCD_1234 to 0x00, strb F, with master done 2 cycles after wr_req, resp 0 → exactly one wr_req pulse carrying those fields; rq_done=2'b01 one cycle later, rq_resp=0.
- **Single read:** req1 reads 0x0C, master returns 0x33333333 with resp 0 → rd_req pulse with addr 0x0C; rq_done=2'b10 with rq_rdata=0x33333333; wr_req never asserted.
- **Contention:** req0 and req1 both held valid from reset release → grant order 0, 1, 0, 1 over four transactions. Then req1 alone for two back-to-back writes → two consecutive completions to req1, with the second grant at the edge after RESP.
- **Response routing:** req0 write, master returns resp 2'b10 → rq_resp=2'b10 on req0's done only; a following req1 read returns resp 0.
- **Spurious done:** wr_done and rd_done pulsed in IDLE, then rd_done pulsed in WAIT during a write → no rq_done and no state change until wr_done arrives.
- **Reset mid-transaction:** aresetn dropped in WAIT of a req0 read → wr_req/rd_req/busy go 0 immediately. A late rd_done after release is ignored, and the next grant starts from requester 0.
